// File: rtl/abr_rej_sampler_stage.sv
// Rejection sampler: masks each unpacked candidate, keeps those below Q and
// forwards them with a running index through a 2-entry registered output buffer.
module abr_rej_sampler_stage #(
  parameter int          InW      = 24,
  parameter int          MaskW    = 23,
  parameter int unsigned Q        = 8380417,
  parameter int          NumCoeff = 256,
  parameter int          IdxW     = (NumCoeff > 1) ? $clog2(NumCoeff) : 1
) (
  input  logic             clk_i,
  input  logic             rst_b,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic             cand_valid_i,
  input  logic [InW-1:0]   cand_data_i,
  output logic             cand_ready_o,
  output logic             coeff_valid_o,
  output logic [MaskW-1:0] coeff_data_o,
  output logic [IdxW-1:0]  coeff_idx_o,
  input  logic             coeff_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      reject_cnt_o
);

  // issue counter must be able to hold NumCoeff itself
  localparam int          CntW   = $clog2(NumCoeff + 1);
  localparam logic [63:0] QLim   = 64'(Q);
  localparam logic [CntW-1:0] LastIdx = CntW'(NumCoeff - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [1:0]       count_reg;
  logic [MaskW-1:0] data_reg [2];
  logic [IdxW-1:0]  idx_reg  [2];
  logic [CntW-1:0]  issue_reg;
  logic [15:0]      reject_reg;

  logic [MaskW-1:0] masked;
  logic             take;
  logic             accept;
  logic             push;
  logic             pop;
  logic             last_accept;
  logic [IdxW-1:0]  push_idx;

  if (InW > MaskW) begin : g_drop
    logic unused_high;
    assign unused_high = ^cand_data_i[InW-1:MaskW];
  end

  assign masked      = cand_data_i[MaskW-1:0];
  assign take        = cand_valid_i && cand_ready_o;
  assign accept      = take && (64'(masked) < QLim);
  assign push        = accept;
  assign pop         = coeff_valid_o && coeff_ready_i;
  assign last_accept = accept && (issue_reg == LastIdx);
  assign push_idx    = issue_reg[IdxW-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_b || clr_i) begin
      state_reg   <= IDLE;
      count_reg   <= 2'd0;
      issue_reg   <= '0;
      reject_reg  <= 16'd0;
      data_reg[0] <= '0;
      data_reg[1] <= '0;
      idx_reg[0]  <= '0;
      idx_reg[1]  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg  <= RUN;
            issue_reg  <= '0;
            reject_reg <= 16'd0;
          end
        end
        RUN: begin
          if (accept) begin
            issue_reg <= issue_reg + 1'b1;
          end else if (take && reject_reg != 16'hFFFF) begin
            reject_reg <= reject_reg + 16'd1;
          end
          if (last_accept) state_reg <= DRAIN;
        end
        // leave as soon as the buffer is, or is about to become, empty
        DRAIN: begin
          if (count_reg == 2'd0 || (count_reg == 2'd1 && pop)) state_reg <= DONE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      case ({push, pop})
        2'b10: begin
          data_reg[count_reg[0]] <= masked;
          idx_reg[count_reg[0]]  <= push_idx;
          count_reg              <= count_reg + 2'd1;
        end
        2'b01: begin
          data_reg[0] <= data_reg[1];
          idx_reg[0]  <= idx_reg[1];
          count_reg   <= count_reg - 2'd1;
        end
        // push only happens below full, so here occupancy is 1
        2'b11: begin
          data_reg[0] <= masked;
          idx_reg[0]  <= push_idx;
        end
        default: ;
      endcase
    end
  end

  assign cand_ready_o  = (state_reg == RUN) && (count_reg != 2'd2);
  assign coeff_valid_o = (count_reg != 2'd0);
  assign coeff_data_o  = data_reg[0];
  assign coeff_idx_o   = idx_reg[0];
  assign busy_o        = (state_reg == RUN) || (state_reg == DRAIN);
  assign done_o        = (state_reg == DONE);
  assign reject_cnt_o  = reject_reg;

endmodule

// File: tb/tb_abr_rej_sampler_stage.sv
// Directed bench for abr_rej_sampler_stage with NumCoeff=4 and default Q/masking.
module tb_abr_rej_sampler_stage;

  logic        clk_i = 1'b0;
  logic        rst_b = 1'b0;
  logic        clr_i = 1'b0;
  logic        start_i = 1'b0;
  logic        cand_valid_i = 1'b0;
  logic [23:0] cand_data_i = '0;
  logic        cand_ready_o;
  logic        coeff_valid_o;
  logic [22:0] coeff_data_o;
  logic [1:0]  coeff_idx_o;
  logic        coeff_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] reject_cnt_o;

  abr_rej_sampler_stage #(.InW(24), .MaskW(23), .Q(8380417), .NumCoeff(4)) dut (
    .clk_i(clk_i), .rst_b(rst_b), .clr_i(clr_i), .start_i(start_i),
    .cand_valid_i(cand_valid_i), .cand_data_i(cand_data_i), .cand_ready_o(cand_ready_o),
    .coeff_valid_o(coeff_valid_o), .coeff_data_o(coeff_data_o), .coeff_idx_o(coeff_idx_o),
    .coeff_ready_i(coeff_ready_i), .busy_o(busy_o), .done_o(done_o), .reject_cnt_o(reject_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int take_cnt = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  logic [22:0] got_data[$];
  logic [1:0]  got_idx[$];

  // sample away from the active edge
  always @(negedge clk_i) begin
    cyc++;
    if (coeff_valid_o && coeff_ready_i) begin
      got_data.push_back(coeff_data_o);
      got_idx.push_back(coeff_idx_o);
      last_pop_cyc = cyc;
      $display("pop  data=%0h idx=%0d", coeff_data_o, coeff_idx_o);
    end
    if (cand_valid_i && cand_ready_o) take_cnt++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [23:0] d);
    int n;
    n = 0;
    cand_valid_i = 1'b1;
    cand_data_i  = d;
    @(negedge clk_i);
    while (!cand_ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (!cand_ready_o) chk_eq("send_timeout", 32'(cand_ready_o), 32'd1);
    tick();
    cand_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    tick();
    repeat (3) tick();
    chk_eq("done_once", 32'(done_cnt), 32'(base + 1));
  endtask

  task automatic check_out(input int i, input logic [22:0] d, input logic [1:0] idx);
    if (got_data.size() > i) begin
      chk_eq($sformatf("out%0d_data", i), 32'(got_data[i]), 32'(d));
      chk_eq($sformatf("out%0d_idx", i), 32'(got_idx[i]), 32'(idx));
    end else begin
      chk_eq($sformatf("out%0d_missing", i), 32'(got_data.size()), 32'(i + 1));
    end
  endtask

  task automatic clear_log();
    got_data.delete();
    got_idx.delete();
    take_cnt = 0;
  endtask

  initial begin
    int base;
    int h;
    logic hs;

    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_eq("rst_cand_ready", 32'(cand_ready_o), 32'd0);
    chk_eq("rst_coeff_valid", 32'(coeff_valid_o), 32'd0);
    chk_eq("rst_coeff_data", 32'(coeff_data_o), 32'd0);
    chk_eq("rst_coeff_idx", 32'(coeff_idx_o), 32'd0);
    chk_eq("rst_busy", 32'(busy_o), 32'd0);
    chk_eq("rst_done", 32'(done_o), 32'd0);
    chk_eq("rst_reject", 32'(reject_cnt_o), 32'd0);
    tick();
    rst_b = 1'b1;
    tick();

    // basic run
    clear_log();
    base = done_cnt;
    coeff_ready_i = 1'b1;
    pulse_start();
    send(24'd5);
    send(24'd8380417);
    send(24'd8380416);
    send(24'h800003);
    send(24'd7);
    wait_done(base);
    check_out(0, 23'd5, 2'd0);
    check_out(1, 23'd8380416, 2'd1);
    check_out(2, 23'd3, 2'd2);
    check_out(3, 23'd7, 2'd3);
    chk_eq("basic_npop", 32'(got_data.size()), 32'd4);
    chk_eq("basic_reject", 32'(reject_cnt_o), 32'd1);
    chk_eq("basic_done_lat", 32'(done_cyc), 32'(last_pop_cyc + 1));
    chk_eq("basic_idle_busy", 32'(busy_o), 32'd0);

    // backpressure
    clear_log();
    base = done_cnt;
    coeff_ready_i = 1'b0;
    pulse_start();
    send(24'd5);
    send(24'd6);
    cand_valid_i = 1'b1;
    cand_data_i  = 24'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk_eq("bp_ready_low", 32'(cand_ready_o), 32'd0);
      chk_eq("bp_hold_data", 32'(coeff_valid_o ? coeff_data_o : 23'h7FFFFF), 32'd5);
      chk_eq("bp_hold_idx", 32'(coeff_idx_o), 32'd0);
    end
    tick();
    coeff_ready_i = 1'b1;
    send(24'd7);
    send(24'd8);
    wait_done(base);
    check_out(0, 23'd5, 2'd0);
    check_out(1, 23'd6, 2'd1);
    check_out(2, 23'd7, 2'd2);
    check_out(3, 23'd8, 2'd3);
    chk_eq("bp_takes", 32'(take_cnt), 32'd4);

    // boundary values
    clear_log();
    base = done_cnt;
    pulse_start();
    send(24'h7FE001);
    send(24'h7FE000);
    send(24'hFFFFFF);
    send(24'hFFE000);
    send(24'd1);
    send(24'd2);
    wait_done(base);
    check_out(0, 23'h7FE000, 2'd0);
    check_out(1, 23'h7FE000, 2'd1);
    check_out(2, 23'd1, 2'd2);
    chk_eq("bnd_reject", 32'(reject_cnt_o), 32'd2);

    // termination under a continuous stream
    clear_log();
    base = done_cnt;
    pulse_start();
    cand_valid_i = 1'b1;
    cand_data_i  = 24'd10;
    h = 0;
    for (int k = 0; k < 30 && h < 4; k++) begin
      @(negedge clk_i);
      hs = cand_ready_o;
      tick();
      if (hs) begin
        h++;
        cand_data_i = cand_data_i + 24'd1;
      end
    end
    @(negedge clk_i);
    chk_eq("term_drain_ready", 32'(cand_ready_o), 32'd0);
    chk_eq("term_drain_busy", 32'(busy_o), 32'd1);
    tick();
    wait_done(base);
    chk_eq("term_takes", 32'(take_cnt), 32'd4);
    cand_valid_i = 1'b0;
    check_out(0, 23'd10, 2'd0);
    check_out(3, 23'd13, 2'd3);

    // abort with one buffered entry, clr and start together
    clear_log();
    coeff_ready_i = 1'b0;
    pulse_start();
    send(24'd8380417);
    send(24'd5);
    @(negedge clk_i);
    chk_eq("abort_pre_reject", 32'(reject_cnt_o), 32'd1);
    chk_eq("abort_pre_valid", 32'(coeff_valid_o), 32'd1);
    tick();
    base = done_cnt;
    clr_i = 1'b1;
    start_i = 1'b1;
    tick();
    clr_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    chk_eq("abort_valid", 32'(coeff_valid_o), 32'd0);
    chk_eq("abort_busy", 32'(busy_o), 32'd0);
    chk_eq("abort_reject", 32'(reject_cnt_o), 32'd0);
    tick();
    repeat (3) tick();
    chk_eq("abort_no_done", 32'(done_cnt), 32'(base));
    clear_log();
    coeff_ready_i = 1'b1;
    pulse_start();
    send(24'd9);
    send(24'd1);
    send(24'd2);
    send(24'd3);
    wait_done(base);
    check_out(0, 23'd9, 2'd0);
    check_out(3, 23'd3, 2'd3);

    // reject counter saturation
    clear_log();
    base = done_cnt;
    pulse_start();
    cand_valid_i = 1'b1;
    cand_data_i  = 24'hFFFFFF;
    repeat (70000) @(posedge clk_i);
    #1;
    cand_valid_i = 1'b0;
    @(negedge clk_i);
    chk_eq("sat_reject", 32'(reject_cnt_o), 32'hFFFF);
    chk_eq("sat_busy", 32'(busy_o), 32'd1);
    tick();
    clear_log();
    send(24'd42);
    send(24'd1);
    send(24'd2);
    send(24'd3);
    wait_done(base);
    check_out(0, 23'd42, 2'd0);
    chk_eq("sat_hold", 32'(reject_cnt_o), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
